// File: rtl/komut_verici.sv
// komut_verici: two-button UART command sender.
//
// Each active-low button is synchronised, debounced and turned into a one-clock
// press event that sets a per-button pending flag. A TX FSM drains the flags
// (forward first) and sends the command byte followed by CR as a back-to-back
// 8N1 frame pair, LSB first.
//
// Ports:
//   saatDarbesi    in   clock, rising edge
//   sifirlama      in   synchronous active-high reset
//   butonIleri     in   forward button, async, active-low
//   butonGeri      in   reverse button, async, active-low
//   gidenVeri      out  UART TX line, idle high (registered)
//   mesgul         out  high while a frame pair is in progress (registered)
//   gonderilenSayi out  completed frame-pair count, wraps at 256 (registered)
module komut_verici #(
    parameter int unsigned BAUD_BOLME    = 5208,
    parameter int unsigned DEBOUNCE_SAYI = 800000,
    parameter logic [7:0]  KOMUT_ILERI   = 8'h69,
    parameter logic [7:0]  KOMUT_GERI    = 8'h67
) (
    input  logic       saatDarbesi,
    input  logic       sifirlama,
    input  logic       butonIleri,
    input  logic       butonGeri,
    output logic       gidenVeri,
    output logic       mesgul,
    output logic [7:0] gonderilenSayi
);

    localparam logic [19:0] DEB_SON = 20'(DEBOUNCE_SAYI - 1);
    localparam logic [15:0] BIT_SON = 16'(BAUD_BOLME - 1);
    localparam logic [7:0]  KOMUT_CR = 8'h0D;

    typedef enum logic [1:0] {BOSTA, BASLA, VERI, DUR} durum_t;

    // Index 0 = forward button, index 1 = reverse button.
    logic [1:0]       r_senk1;
    logic [1:0]       r_senk2;
    logic [1:0]       r_seviye;
    logic [1:0][19:0] r_deb_sayac;
    logic [1:0]       r_bekle;

    durum_t      r_durum;
    logic [7:0]  r_bayt;
    logic        r_indeks;
    logic [15:0] r_bit_sayac;
    logic [2:0]  r_bit_no;
    logic        r_tx;
    logic        r_mesgul;
    logic [7:0]  r_sayi;

    logic [1:0]       w_seviye_d;
    logic [1:0][19:0] w_deb_sayac_d;
    logic [1:0]       w_bas;
    logic [1:0]       w_temizle;
    logic [1:0]       w_bekle_d;

    durum_t      w_durum_d;
    logic [7:0]  w_bayt_d;
    logic        w_indeks_d;
    logic [15:0] w_bit_sayac_d;
    logic [2:0]  w_bit_no_d;
    logic        w_tx_d;
    logic        w_mesgul_d;
    logic [7:0]  w_sayi_d;
    logic        w_bit_son;

    // Debounce: the level follows the synchronised input only after it has
    // disagreed for DEBOUNCE_SAYI clocks in a row. The press event fires in the
    // same cycle the level is about to fall, so the flag is set on that edge.
    always_comb begin
        w_seviye_d    = r_seviye;
        w_deb_sayac_d = r_deb_sayac;
        w_bas         = 2'b00;
        for (int k = 0; k < 2; k++) begin
            if (r_senk2[k] != r_seviye[k]) begin
                if (r_deb_sayac[k] == DEB_SON) begin
                    w_seviye_d[k]    = r_senk2[k];
                    w_deb_sayac_d[k] = '0;
                    w_bas[k]         = ~r_senk2[k];
                end else begin
                    w_deb_sayac_d[k] = r_deb_sayac[k] + 20'd1;
                end
            end else begin
                w_deb_sayac_d[k] = '0;
            end
        end
    end

    assign w_bit_son = (r_bit_sayac == BIT_SON);

    // TX FSM next state and outputs.
    always_comb begin
        w_durum_d     = r_durum;
        w_bayt_d      = r_bayt;
        w_indeks_d    = r_indeks;
        w_bit_sayac_d = r_bit_sayac;
        w_bit_no_d    = r_bit_no;
        w_tx_d        = r_tx;
        w_mesgul_d    = r_mesgul;
        w_sayi_d      = r_sayi;
        w_temizle     = 2'b00;

        case (r_durum)
            BOSTA: begin
                if (r_bekle != 2'b00) begin
                    w_durum_d     = BASLA;
                    w_tx_d        = 1'b0;
                    w_mesgul_d    = 1'b1;
                    w_indeks_d    = 1'b0;
                    w_bit_sayac_d = '0;
                    if (r_bekle[0]) begin
                        w_bayt_d     = KOMUT_ILERI;
                        w_temizle[0] = 1'b1;
                    end else begin
                        w_bayt_d     = KOMUT_GERI;
                        w_temizle[1] = 1'b1;
                    end
                end
            end
            BASLA: begin
                if (w_bit_son) begin
                    w_durum_d     = VERI;
                    w_bit_sayac_d = '0;
                    w_bit_no_d    = 3'd0;
                    w_tx_d        = r_bayt[0];
                    w_bayt_d      = {1'b0, r_bayt[7:1]};
                end else begin
                    w_bit_sayac_d = r_bit_sayac + 16'd1;
                end
            end
            VERI: begin
                if (w_bit_son) begin
                    w_bit_sayac_d = '0;
                    if (r_bit_no == 3'd7) begin
                        w_durum_d = DUR;
                        w_tx_d    = 1'b1;
                    end else begin
                        w_bit_no_d = r_bit_no + 3'd1;
                        w_tx_d     = r_bayt[0];
                        w_bayt_d   = {1'b0, r_bayt[7:1]};
                    end
                end else begin
                    w_bit_sayac_d = r_bit_sayac + 16'd1;
                end
            end
            DUR: begin
                if (w_bit_son) begin
                    w_bit_sayac_d = '0;
                    if (!r_indeks) begin
                        // Command byte done: CR follows with no idle gap.
                        w_durum_d  = BASLA;
                        w_tx_d     = 1'b0;
                        w_bayt_d   = KOMUT_CR;
                        w_indeks_d = 1'b1;
                    end else begin
                        w_durum_d  = BOSTA;
                        w_tx_d     = 1'b1;
                        w_mesgul_d = 1'b0;
                        w_sayi_d   = r_sayi + 8'd1;
                    end
                end else begin
                    w_bit_sayac_d = r_bit_sayac + 16'd1;
                end
            end
            default: begin
                w_durum_d = BOSTA;
            end
        endcase
    end

    // A press in the same cycle its flag is consumed keeps the flag set.
    assign w_bekle_d = (r_bekle & ~w_temizle) | w_bas;

    always_ff @(posedge saatDarbesi) begin
        if (sifirlama) begin
            r_senk1     <= 2'b11;
            r_senk2     <= 2'b11;
            r_seviye    <= 2'b11;
            r_deb_sayac <= '0;
            r_bekle     <= 2'b00;
            r_durum     <= BOSTA;
            r_bayt      <= 8'h00;
            r_indeks    <= 1'b0;
            r_bit_sayac <= '0;
            r_bit_no    <= 3'd0;
            r_tx        <= 1'b1;
            r_mesgul    <= 1'b0;
            r_sayi      <= 8'h00;
        end else begin
            r_senk1     <= {butonGeri, butonIleri};
            r_senk2     <= r_senk1;
            r_seviye    <= w_seviye_d;
            r_deb_sayac <= w_deb_sayac_d;
            r_bekle     <= w_bekle_d;
            r_durum     <= w_durum_d;
            r_bayt      <= w_bayt_d;
            r_indeks    <= w_indeks_d;
            r_bit_sayac <= w_bit_sayac_d;
            r_bit_no    <= w_bit_no_d;
            r_tx        <= w_tx_d;
            r_mesgul    <= w_mesgul_d;
            r_sayi      <= w_sayi_d;
        end
    end

    assign gidenVeri      = r_tx;
    assign mesgul         = r_mesgul;
    assign gonderilenSayi = r_sayi;

endmodule
